// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC select encoding, defaults and alignment helper
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_BRANCH,
        SEL_RET,
        SEL_JUMP,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_PC_LIMIT  = 127;

    // Clears the low log2(step) bits; step is a power of two.
    function automatic logic [63:0] align_mask(input int unsigned step);
        return ~(64'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-redirect request and PC result bundle
interface pc_sequencer_if #(
    parameter int unsigned AW = 32
);
    logic          Stall;
    logic          BranchTaken;
    logic [AW-1:0] BranchTarget;
    logic          Jump;
    logic [AW-1:0] JumpTarget;
    logic          Call;
    logic          Ret;
    logic [AW-1:0] PC;
    logic [AW-1:0] PCNext;
    logic          Valid;
    logic          Wrapped;
    logic          Misaligned;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Call, Ret,
        input  PC, PCNext, Valid, Wrapped, Misaligned
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Call, Ret,
        output PC, PCNext, Valid, Wrapped, Misaligned
    );
endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; overflow overwrites the oldest entry
module pc_ras #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [AW-1:0] i_data,
    output logic [AW-1:0] o_top,
    output logic          o_empty,
    output logic          o_full
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_top_idx;
    logic [PW-1:0] w_wr_idx;
    logic          w_pop_eff;

    assign w_top_idx = r_ptr - 1'b1;
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign w_pop_eff = i_pop && !o_empty;
    // Pop+push in one cycle rewrites the current top in place.
    assign w_wr_idx  = w_pop_eff ? w_top_idx : r_ptr;

    always_ff @(posedge Clk) begin
        if (!Reset && i_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (w_pop_eff && !i_push) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end else if (i_push && !w_pop_eff) begin
            r_ptr   <= r_ptr + 1'b1;
            if (!o_full) begin
                r_count <= r_count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter with redirect, stall and range wrap
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned    AW        = 32,
    parameter int unsigned    STEP      = 4,
    parameter logic [AW-1:0]  RESET_VEC = AW'(DEF_RESET_VEC),
    parameter logic [AW-1:0]  PC_LIMIT  = AW'(DEF_PC_LIMIT),
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    pc_sequencer_if.slave   bus
);
    logic [AW-1:0] r_pc;
    logic          r_valid;
    logic          r_wrapped;
    logic          r_misaligned;

    pc_sel_e       w_sel;
    logic [AW-1:0] w_mask;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_raw;
    logic [AW-1:0] w_ret_target;
    logic [AW-1:0] w_cand;
    logic          w_redirect;
    logic          w_misalign;
    logic          w_wrap;

    assign w_mask    = AW'(align_mask(STEP));
    assign w_pc_next = r_pc + AW'(STEP);

`ifdef PC_RAS_EN
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_ras_top;
    logic          w_ras_empty;
    logic          w_unused_ras_full;

    // Only the winning operation touches the stack; Ret+Call replaces the top.
    assign w_pop  = (w_sel == SEL_RET);
    assign w_push = bus.Call && ((w_sel == SEL_JUMP) || (w_sel == SEL_RET));
    assign w_ret_target = w_ras_empty ? RESET_VEC : w_ras_top;

    pc_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_next),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_unused_ras_full)
    );
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic w_unused_call;

    assign w_unused_call = bus.Call;
    assign w_ret_target  = bus.JumpTarget;
`endif

    // The first edge out of reset publishes RESET_VEC as a valid fetch before advancing.
    always_comb begin
        w_sel = SEL_SEQ;
        if (Reset)                w_sel = SEL_RESET;
        else if (!r_valid)        w_sel = SEL_HOLD;
        else if (bus.BranchTaken) w_sel = SEL_BRANCH;
        else if (bus.Ret)         w_sel = SEL_RET;
        else if (bus.Jump)        w_sel = SEL_JUMP;
        else if (bus.Stall)       w_sel = SEL_HOLD;
    end

    always_comb begin
        w_raw      = bus.JumpTarget;
        w_redirect = 1'b0;
        case (w_sel)
            SEL_BRANCH: begin w_raw = bus.BranchTarget; w_redirect = 1'b1; end
            SEL_RET:    begin w_raw = w_ret_target;     w_redirect = 1'b1; end
            SEL_JUMP:   begin w_raw = bus.JumpTarget;   w_redirect = 1'b1; end
            default:    ;
        endcase
        w_misalign = w_redirect && ((w_raw & ~w_mask) != '0);
        w_cand     = w_redirect ? (w_raw & w_mask) : w_pc_next;
        w_wrap     = (w_cand > PC_LIMIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc         <= RESET_VEC;
            r_valid      <= 1'b0;
            r_wrapped    <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_valid      <= 1'b1;
            r_wrapped    <= 1'b0;
            r_misaligned <= 1'b0;
            if (w_sel != SEL_HOLD) begin
                r_pc         <= w_wrap ? RESET_VEC : w_cand;
                r_wrapped    <= w_wrap;
                r_misaligned <= w_misalign;
            end
        end
    end

    assign bus.PC         = r_pc;
    assign bus.PCNext     = w_pc_next;
    assign bus.Valid      = r_valid;
    assign bus.Wrapped    = r_wrapped;
    assign bus.Misaligned = r_misaligned;
endmodule
